// File: rtl/data_sync_tx_if.sv
// Upstream word handshake into the DATA_SYNC launcher.
// The upstream side drives the word and valid, and the launcher answers with ready.
interface data_sync_tx_if #(
    parameter int BUS_WIDTH = 8
) ();
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/data_sync_tx.sv
// Source-domain launcher for DATA_SYNC: holds unsync_bus stable while the far side captures it,
// either for a fixed number of cycles or until a four-phase ack handshake completes.
//
// state   | meaning
// IDLE    | waiting for a word; the bus keeps the last word sent
// ENA     | timed mode: bus_enable high, counting ENABLE_CYCLES
// GUARD   | timed mode: bus_enable low, bus held for GUARD_CYCLES
// REQ     | ack mode: bus_enable high, waiting for the synchronized ack to rise
// ACKLO   | ack mode: bus_enable low, waiting for the synchronized ack to fall
module data_sync_tx #(
    parameter int BUS_WIDTH     = 8,
    parameter int NUM_STAGES    = 2,
    parameter int USE_ACK       = 1,
    parameter int ENABLE_CYCLES = 3,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_sync_tx_if.slave        tx_if,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy
);
    localparam int MAX_CNT = (ENABLE_CYCLES > GUARD_CYCLES) ? ENABLE_CYCLES : GUARD_CYCLES;
    localparam int CW      = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
    localparam logic [CW-1:0] ENA_LOAD = CW'(ENABLE_CYCLES - 1);
    localparam logic [CW-1:0] GRD_LOAD = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENA,
        S_GUARD,
        S_REQ,
        S_ACKLO
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         count, count_nxt;
    logic [BUS_WIDTH-1:0]  bus_nxt;
    logic                  en_nxt;
    logic [NUM_STAGES-1:0] ack_sync;
    logic                  ack_s;
    logic                  tx_ready;
    logic                  accept;

    assign ack_s  = ack_sync[NUM_STAGES-1];
    assign accept = tx_if.tx_valid && tx_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            count      <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            ack_sync   <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            unsync_bus <= bus_nxt;
            bus_enable <= en_nxt;
            ack_sync   <= {ack_sync[NUM_STAGES-2:0], ack_async};
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        bus_nxt   = unsync_bus;
        en_nxt    = bus_enable;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    bus_nxt   = tx_if.tx_data;
                    en_nxt    = 1'b1;
                    count_nxt = ENA_LOAD;
                    state_nxt = (USE_ACK != 0) ? S_REQ : S_ENA;
                end
            end
            S_ENA: begin
                if (count == '0) begin
                    en_nxt = 1'b0;
                    if (GUARD_CYCLES == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_GUARD;
                        count_nxt = GRD_LOAD;
                    end
                end else begin
                    count_nxt = count - CNT_ONE;
                end
            end
            S_GUARD: begin
                if (count == '0) state_nxt = S_IDLE;
                else             count_nxt = count - CNT_ONE;
            end
            S_REQ: begin
                if (ack_s) begin
                    en_nxt    = 1'b0;
                    state_nxt = S_ACKLO;
                end
            end
            S_ACKLO: begin
                if (!ack_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ready comes from registers only; a stale ack blocks acceptance until it clears.
    always_comb begin
        tx_ready       = (state == S_IDLE) && !((USE_ACK != 0) && ack_s);
        busy           = (state != S_IDLE);
        tx_if.tx_ready = tx_ready;
    end
endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx: one timed-mode and one ack-mode instance on a shared clock and reset.
module tb_data_sync_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ack_t = 1'b0;
    logic       ack_a = 1'b0;
    logic [7:0] bus_t, bus_a;
    logic       en_t, en_a, busy_t, busy_a;
    int         n_checks = 0;
    int         n_fail   = 0;

    data_sync_tx_if #(.BUS_WIDTH(8)) if_t ();
    data_sync_tx_if #(.BUS_WIDTH(8)) if_a ();

    always #5 CLK = ~CLK;

    data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .USE_ACK(0),
                   .ENABLE_CYCLES(3), .GUARD_CYCLES(4)) u_timed (
        .CLK(CLK), .RST(RST), .tx_if(if_t.slave), .ack_async(ack_t),
        .unsync_bus(bus_t), .bus_enable(en_t), .busy(busy_t));

    data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .USE_ACK(1),
                   .ENABLE_CYCLES(3), .GUARD_CYCLES(4)) u_ack (
        .CLK(CLK), .RST(RST), .tx_if(if_a.slave), .ack_async(ack_a),
        .unsync_bus(bus_a), .bus_enable(en_a), .busy(busy_a));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        if_t.tx_valid = 1'b1; if_t.tx_data = 8'hAA;
        if_a.tx_valid = 1'b1; if_a.tx_data = 8'hAA;
        repeat (3) tick();
        n_checks++; if (bus_t !== 8'h00) begin n_fail++; $display("FAIL reset_bus_t: got %h want 00", bus_t); end
        n_checks++; if (en_t !== 1'b0) begin n_fail++; $display("FAIL reset_en_t: got %b want 0", en_t); end
        n_checks++; if (if_t.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_t: got %b want 1", if_t.tx_ready); end
        n_checks++; if (busy_t !== 1'b0) begin n_fail++; $display("FAIL reset_busy_t: got %b want 0", busy_t); end
        n_checks++; if (bus_a !== 8'h00) begin n_fail++; $display("FAIL reset_bus_a: got %h want 00", bus_a); end
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL reset_en_a: got %b want 0", en_a); end
        n_checks++; if (if_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b want 1", if_a.tx_ready); end
        if_t.tx_valid = 1'b0;
        if_a.tx_valid = 1'b0;
        RST = 1'b1;
        tick();
        n_checks++; if (busy_t !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b%b want 00", busy_t, busy_a); end
    endtask

    task automatic test_timed_back_to_back();
        logic [7:0] exp_bus;
        logic       exp_en, exp_rdy;
        if_t.tx_data = 8'hAA; if_t.tx_valid = 1'b1;
        tick();
        if_t.tx_data = 8'hBB;
        for (int i = 0; i <= 8; i++) begin
            exp_en  = (i < 3) || (i == 8);
            exp_bus = (i < 8) ? 8'hAA : 8'hBB;
            exp_rdy = (i == 7);
            n_checks++; if (en_t !== exp_en) begin n_fail++; $display("FAIL timed_en[%0d]: got %b want %b", i, en_t, exp_en); end
            n_checks++; if (bus_t !== exp_bus) begin n_fail++; $display("FAIL timed_bus[%0d]: got %h want %h", i, bus_t, exp_bus); end
            n_checks++; if (if_t.tx_ready !== exp_rdy) begin n_fail++; $display("FAIL timed_ready[%0d]: got %b want %b", i, if_t.tx_ready, exp_rdy); end
            if (i < 8) tick();
        end
        if_t.tx_valid = 1'b0;
        repeat (8) tick();
        n_checks++; if (if_t.tx_ready !== 1'b1 || en_t !== 1'b0 || bus_t !== 8'hBB) begin
            n_fail++; $display("FAIL timed_done: got rdy=%b en=%b bus=%h want 1 0 bb", if_t.tx_ready, en_t, bus_t);
        end
    endtask

    task automatic test_ack_mode();
        if_a.tx_data = 8'hCC; if_a.tx_valid = 1'b1;
        tick();
        if_a.tx_valid = 1'b0;
        n_checks++; if (en_a !== 1'b1 || bus_a !== 8'hCC || if_a.tx_ready !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL ack_accept: got en=%b bus=%h rdy=%b busy=%b want 1 cc 0 1", en_a, bus_a, if_a.tx_ready, busy_a);
        end
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_checks++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL ack_wait_en[%0d]: got %b want 1", j, en_a); end
        end
        ack_a = 1'b1;
        tick();
        n_checks++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL ack_edge0_en: got %b want 1", en_a); end
        tick();
        n_checks++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL ack_edge1_en: got %b want 1", en_a); end
        tick();
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL ack_edge2_en: got %b want 0", en_a); end
        n_checks++; if (bus_a !== 8'hCC || if_a.tx_ready !== 1'b0) begin n_fail++; $display("FAIL ack_hold: got bus=%h rdy=%b want cc 0", bus_a, if_a.tx_ready); end
        ack_a = 1'b0;
        tick();
        n_checks++; if (if_a.tx_ready !== 1'b0) begin n_fail++; $display("FAIL acklo_edge0_ready: got %b want 0", if_a.tx_ready); end
        tick();
        n_checks++; if (if_a.tx_ready !== 1'b0) begin n_fail++; $display("FAIL acklo_edge1_ready: got %b want 0", if_a.tx_ready); end
        tick();
        n_checks++; if (if_a.tx_ready !== 1'b1 || busy_a !== 1'b0 || bus_a !== 8'hCC) begin
            n_fail++; $display("FAIL acklo_edge2: got rdy=%b busy=%b bus=%h want 1 0 cc", if_a.tx_ready, busy_a, bus_a);
        end
    endtask

    task automatic test_stale_ack();
        ack_a = 1'b1;
        repeat (2) tick();
        if_a.tx_data = 8'hDD; if_a.tx_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++; if (if_a.tx_ready !== 1'b0 || bus_a !== 8'hCC || busy_a !== 1'b0) begin
                n_fail++; $display("FAIL stale_block[%0d]: got rdy=%b bus=%h busy=%b want 0 cc 0", j, if_a.tx_ready, bus_a, busy_a);
            end
        end
        ack_a = 1'b0;
        tick();
        n_checks++; if (if_a.tx_ready !== 1'b0 || bus_a !== 8'hCC) begin n_fail++; $display("FAIL stale_drop0: got rdy=%b bus=%h want 0 cc", if_a.tx_ready, bus_a); end
        tick();
        n_checks++; if (if_a.tx_ready !== 1'b1 || bus_a !== 8'hCC) begin n_fail++; $display("FAIL stale_drop1: got rdy=%b bus=%h want 1 cc", if_a.tx_ready, bus_a); end
        tick();
        if_a.tx_valid = 1'b0;
        n_checks++; if (bus_a !== 8'hDD || en_a !== 1'b1) begin n_fail++; $display("FAIL stale_accept: got bus=%h en=%b want dd 1", bus_a, en_a); end
        ack_a = 1'b1;
        repeat (3) tick();
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL stale_req_done: got en=%b want 0", en_a); end
        ack_a = 1'b0;
        repeat (3) tick();
        n_checks++; if (if_a.tx_ready !== 1'b1 || bus_a !== 8'hDD) begin n_fail++; $display("FAIL stale_idle: got rdy=%b bus=%h want 1 dd", if_a.tx_ready, bus_a); end
    endtask

    task automatic test_reset_mid();
        if_t.tx_data = 8'hEE; if_t.tx_valid = 1'b1;
        if_a.tx_data = 8'hEE; if_a.tx_valid = 1'b1;
        tick();
        if_t.tx_valid = 1'b0; if_a.tx_valid = 1'b0;
        tick();
        #1 RST = 1'b0;
        #1;
        n_checks++; if (en_t !== 1'b0 || bus_t !== 8'h00 || busy_t !== 1'b0) begin
            n_fail++; $display("FAIL midrst_timed: got en=%b bus=%h busy=%b want 0 00 0", en_t, bus_t, busy_t);
        end
        n_checks++; if (en_a !== 1'b0 || bus_a !== 8'h00 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ack: got en=%b bus=%h busy=%b want 0 00 0", en_a, bus_a, busy_a);
        end
        tick();
        RST = 1'b1;
        tick();
        if_t.tx_data = 8'hFF; if_t.tx_valid = 1'b1;
        if_a.tx_data = 8'hFF; if_a.tx_valid = 1'b1;
        tick();
        if_t.tx_valid = 1'b0; if_a.tx_valid = 1'b0;
        n_checks++; if (bus_t !== 8'hFF || en_t !== 1'b1) begin n_fail++; $display("FAIL midrst_next_t: got bus=%h en=%b want ff 1", bus_t, en_t); end
        n_checks++; if (bus_a !== 8'hFF || en_a !== 1'b1) begin n_fail++; $display("FAIL midrst_next_a: got bus=%h en=%b want ff 1", bus_a, en_a); end
        ack_a = 1'b1;
        repeat (7) tick();
        n_checks++; if (if_t.tx_ready !== 1'b1 || en_t !== 1'b0 || bus_t !== 8'hFF) begin
            n_fail++; $display("FAIL midrst_done_t: got rdy=%b en=%b bus=%h want 1 0 ff", if_t.tx_ready, en_t, bus_t);
        end
        n_checks++; if (en_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL midrst_acklo_a: got en=%b busy=%b want 0 1", en_a, busy_a); end
        ack_a = 1'b0;
        repeat (3) tick();
        n_checks++; if (if_a.tx_ready !== 1'b1 || bus_a !== 8'hFF) begin n_fail++; $display("FAIL midrst_done_a: got rdy=%b bus=%h want 1 ff", if_a.tx_ready, bus_a); end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [3];
        logic [7:0] got   [8];
        int         idx  = 0;
        int         ncap = 0;
        logic       hs;
        logic       en_prev;
        words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        en_prev = en_t;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (idx == 3 && !busy_t) break;
            if_t.tx_valid = (idx < 3) && ((cyc % 3) != 1);
            if_t.tx_data  = words[(idx < 3) ? idx : 2];
            hs = if_t.tx_valid && if_t.tx_ready;
            tick();
            if (en_t && !en_prev) begin
                if (ncap < 8) got[ncap] = bus_t;
                ncap++;
            end
            en_prev = en_t;
            if (hs) idx++;
        end
        if_t.tx_valid = 1'b0;
        n_checks++; if (idx !== 3 || busy_t !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got accepted=%0d busy=%b want 3 0", idx, busy_t); end
        n_checks++; if (ncap !== 3) begin n_fail++; $display("FAIL bp_count: got %0d transfers want 3", ncap); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (got[k] !== words[k]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], words[k]); end
        end
    endtask

    initial begin
        if_t.tx_valid = 1'b0; if_t.tx_data = 8'h00;
        if_a.tx_valid = 1'b0; if_a.tx_data = 8'h00;
        test_reset();
        test_timed_back_to_back();
        test_ack_mode();
        test_stale_ack();
        test_reset_mid();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
